mux_2_1: RTL and testbench

MUX_2_1 -- requirements
Module: mux_2_1

---
 rtl/mux_2_1.sv | 29 ++
 tb/tb_mux_2_1.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mux_2_1.sv
// mux_2_1: gate-level 2:1 mux of WIDTH bits with a shared inverted select,
// plus a registered copy of the result (async active-high reset).
`timescale 1ns/10ps
module mux_2_1 #(
    parameter int  WIDTH      = 1,
    parameter real GATE_DELAY = 0.05
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q
);
    logic             sel_n;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] a1;
    not #(GATE_DELAY) u_not (sel_n, sel);
    // Independent slices: each bit only sees its own i0/i1 and the shared select.
    for (genvar x = 0; x < WIDTH; x++) begin : g_bit
        and #(GATE_DELAY) u_and0 (a0[x], i0[x], sel_n);
        and #(GATE_DELAY) u_and1 (a1[x], i1[x], sel);
        or  #(GATE_DELAY) u_or   (out[x], a0[x], a1[x]);
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) out_q <= '0;
        else       out_q <= out;
endmodule

// File: tb/tb_mux_2_1.sv
// tb_mux_2_1: directed checks of a 64-bit mux against 64 one-bit muxes,
// covering the truth table, select isolation, reset and register timing.
`timescale 1ns/10ps
module tb_mux_2_1;
    typedef struct {
        logic        sel;
        logic [63:0] i0;
        logic [63:0] i1;
        logic [63:0] exp;
    } vec_t;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] PA   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PB   = 64'hFEDC_BA98_7654_3210;
    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [63:0] i0;
    logic [63:0] i1;
    logic [63:0] out;
    logic [63:0] out_q;
    logic [63:0] nout;
    logic [63:0] nout_q;
    int          errors = 0;
    int          checks = 0;
    vec_t        vecs [12];
    always #5 clk = ~clk;
    mux_2_1 #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .i0(i0), .i1(i1), .sel(sel), .out(out), .out_q(out_q)
    );
    for (genvar g = 0; g < 64; g++) begin : g_narrow
        mux_2_1 #(.WIDTH(1)) u (
            .clk(clk), .reset(reset), .i0(i0[g]), .i1(i1[g]), .sel(sel),
            .out(nout[g]), .out_q(nout_q[g])
        );
    end
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    initial begin
        logic [63:0] kept;
        logic [63:0] xexp;
        logic        xprobe;
        vecs[0]  = '{1'b0, 64'h0,  64'h0,  64'h0};
        vecs[1]  = '{1'b0, 64'h0,  ONES,   64'h0};
        vecs[2]  = '{1'b0, ONES,   64'h0,  ONES};
        vecs[3]  = '{1'b0, ONES,   ONES,   ONES};
        vecs[4]  = '{1'b1, 64'h0,  64'h0,  64'h0};
        vecs[5]  = '{1'b1, 64'h0,  ONES,   ONES};
        vecs[6]  = '{1'b1, ONES,   64'h0,  64'h0};
        vecs[7]  = '{1'b1, ONES,   ONES,   ONES};
        vecs[8]  = '{1'b0, PA,     PB,     PA};
        vecs[9]  = '{1'b1, PA,     PB,     PB};
        vecs[10] = '{1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA};
        vecs[11] = '{1'b1, 64'hF0F0_0000_FFFF_0001, 64'h0F0F_1234_0000_8000, 64'h0F0F_1234_0000_8000};
        // Reset state; the mux output must already be valid during reset.
        reset = 1'b1; sel = 1'b0; i0 = ONES; i1 = 64'h0;
        #1;
        chk("reset_out_q", out_q, 64'h0);
        chk("reset_out", out, ONES);
        chk("reset_nout_q", nout_q, 64'h0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("first_load", out_q, ONES);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            sel = vecs[k].sel; i0 = vecs[k].i0; i1 = vecs[k].i1;
            #0.16;
            chk($sformatf("vec%0d_out", k), out, vecs[k].exp);
            chk($sformatf("vec%0d_nout", k), nout, vecs[k].exp);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_q", k), out_q, vecs[k].exp);
            chk($sformatf("vec%0d_nout_q", k), nout_q, vecs[k].exp);
        end
        // Select isolation: the unselected input must never reach out.
        sel = 1'b0; i0 = PA;
        for (int k = 0; k < 20; k++) begin
            i1 = {$urandom, $urandom};
            #0.2;
            chk("iso_sel0", out, PA);
        end
        sel = 1'b1; i1 = PB;
        for (int k = 0; k < 20; k++) begin
            i0 = {$urandom, $urandom};
            #0.2;
            chk("iso_sel1", out, PB);
        end
        // Mid-cycle reset clears out_q at once and holds it across edges.
        @(negedge clk); sel = 1'b0; i0 = ONES;
        @(posedge clk); #1;
        chk("pre_reset_q", out_q, ONES);
        #2; reset = 1'b1;
        #0.2;
        chk("async_clear", out_q, 64'h0);
        chk("async_clear_n", nout_q, 64'h0);
        chk("out_in_reset", out, ONES);
        @(posedge clk); #1;
        chk("held_in_reset", out_q, 64'h0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("release_load", out_q, ONES);
        // Mid-cycle data change: out follows now, out_q waits for the edge.
        @(negedge clk); i0 = 64'h1234_5678_9ABC_DEF0;
        #0.16;
        chk("mid_out", out, 64'h1234_5678_9ABC_DEF0);
        chk("mid_out_q_hold", out_q, ONES);
        @(posedge clk); #1;
        chk("mid_out_q_load", out_q, 64'h1234_5678_9ABC_DEF0);
        // Unknown select: zeros stay zero; ones become X on a 4-state simulator.
        @(negedge clk); sel = 1'bx; i0 = 64'h0; i1 = 64'h0;
        #0.2;
        chk("selx_zero", out, 64'h0);
        i0 = ONES; i1 = ONES;
        #0.2;
        xprobe = 1'bx;
        xexp = $isunknown(xprobe) ? {64{1'bx}} : ONES;
        chk("selx_one", out, xexp);
        kept = nout;
        chk("selx_narrow", kept, xexp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
